// File: rtl/cpu_step_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_step_pkg
//  Description : Shared types and constants for the CPU run/step controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_step_pkg;

  // Width of the issued-step counter shown on the display path
  localparam int STEP_CNT_W = 32;

  // Controller state; the encoding is visible on the mode output
  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_STEP = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Bits needed to hold the values 0..n-1 (at least one bit)
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_step_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_step_ctrl_if
//  Description : Board-side inputs and CPU-side enable/status outputs of the
//                run/step controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_step_ctrl_if;
  import cpu_step_pkg::*;

  logic                  btnStep;
  logic                  swRun;
  logic                  swSpeed;
  logic                  cpuEn;
  logic [1:0]            mode;
  logic [STEP_CNT_W-1:0] stepCount;

  // Board / stimulus side
  modport master (
    output btnStep, swRun, swSpeed,
    input  cpuEn, mode, stepCount
  );

  // Controller side
  modport slave (
    input  btnStep, swRun, swSpeed,
    output cpuEn, mode, stepCount
  );

endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Two-flop synchronizer, consecutive-sample debounce counter and
//                rising-edge detector for one bouncy asynchronous input.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
  import cpu_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  wire logic CLK,
  input  wire logic RST,
  input  wire logic rawIn,
  output logic      level,
  output logic      rise
);

  // The counter only needs to reach DEBOUNCE_CYCLES-1 before the level flips
  localparam int             CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_s;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] diff_cnt;

  // Two-flop synchronizer on the raw pin
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_meta <= 1'b0;
      sync_s    <= 1'b0;
    end else begin
      sync_meta <= rawIn;
      sync_s    <= sync_meta;
    end
  end

  // Count consecutive samples that disagree with the debounced level; adopt
  // the new value on the last one of the run
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      level_q  <= 1'b0;
      diff_cnt <= '0;
    end else if (sync_s == level_q) begin
      diff_cnt <= '0;
    end else if (diff_cnt == CNT_LAST) begin
      level_q  <= sync_s;
      diff_cnt <= '0;
    end else begin
      diff_cnt <= diff_cnt + 1'b1;
    end
  end

  // Previous debounced level, for the single-cycle rising-edge pulse
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level_q;
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~level_d;

endmodule
`default_nettype wire

// File: rtl/cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_step_ctrl
//  Description : Run/step clock-enable generator for the CPU core. Produces a
//                single-cycle cpuEn strobe while halted (one per debounced
//                button press) or free-running at a fast/slow divided rate,
//                and counts issued steps.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_step_ctrl
  import cpu_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FAST_DIV        = 2,
  parameter int SLOW_DIV        = 25000000
) (
  input  wire logic       CLK,
  input  wire logic       RST,
  cpu_step_ctrl_if.slave  bus
);

  localparam int MAX_DIV = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
  localparam int DIV_W   = cnt_width(MAX_DIV);

  // Terminal divider values (DIV-1) for each speed
  localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(FAST_DIV - 1);
  localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(SLOW_DIV - 1);

  // Synchronized switches
  logic run_meta;
  logic run_s;
  logic spd_meta;
  logic spd_s;
  logic spd_prev;

  // Debounced step button
  logic btn_level;
  logic btn_rise;
  logic step_req;

  // Controller state
  state_t                state;
  state_t                state_next;
  logic [DIV_W-1:0]      div;
  logic [DIV_W-1:0]      div_next;
  logic [DIV_W-1:0]      div_last;
  logic                  spd_toggle;
  logic                  cpu_en;
  logic                  en_next;
  logic [STEP_CNT_W-1:0] step_count;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .CLK   (CLK),
    .RST   (RST),
    .rawIn (bus.btnStep),
    .level (btn_level),
    .rise  (btn_rise)
  );

  // A request is the first cycle of a debounced high level
  assign step_req = btn_rise & btn_level;

  // Two-flop synchronizers for the run and speed switches, plus the previous
  // synchronized speed so a speed change can be seen for one cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      run_meta <= 1'b0;
      run_s    <= 1'b0;
      spd_meta <= 1'b0;
      spd_s    <= 1'b0;
      spd_prev <= 1'b0;
    end else begin
      run_meta <= bus.swRun;
      run_s    <= run_meta;
      spd_meta <= bus.swSpeed;
      spd_s    <= spd_meta;
      spd_prev <= spd_s;
    end
  end

  assign div_last   = spd_s ? SLOW_LAST : FAST_LAST;
  assign spd_toggle = spd_s ^ spd_prev;

  // State, divider and strobe registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= ST_HALT;
      div    <= '0;
      cpu_en <= 1'b0;
    end else begin
      state  <= state_next;
      div    <= div_next;
      cpu_en <= en_next;
    end
  end

  // Next-state, divider and strobe decode. The strobe is registered, so it
  // lands in the cycle after the divider sits at its terminal value.
  always_comb begin
    state_next = state;
    div_next   = div;
    en_next    = 1'b0;
    case (state)
      ST_HALT: begin
        div_next = '0;
        if (run_s) begin
          state_next = ST_RUN;
        end else if (step_req) begin
          state_next = ST_STEP;
          en_next    = 1'b1;
        end
      end
      ST_STEP: begin
        state_next = ST_HALT;
      end
      ST_RUN: begin
        if (!run_s) begin
          state_next = ST_HALT;
          div_next   = '0;
        end else if (spd_toggle && (div >= div_last)) begin
          // Already past the new terminal count: restart without a pulse
          div_next = '0;
        end else if (div == div_last) begin
          div_next = '0;
          en_next  = 1'b1;
        end else begin
          div_next = div + 1'b1;
        end
      end
      default: begin
        state_next = ST_HALT;
        div_next   = '0;
      end
    endcase
  end

  // Count every cycle the CPU was enabled; wraps silently
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      step_count <= '0;
    end else if (cpu_en) begin
      step_count <= step_count + 1'b1;
    end
  end

  assign bus.cpuEn     = cpu_en;
  assign bus.mode      = state;
  assign bus.stepCount = step_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_step_ctrl
//  Description : Self-checking bench for cpu_step_ctrl with a behavioural
//                reference model, a vector table and directed sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_step_ctrl;

  localparam int D  = 4;
  localparam int FD = 2;
  localparam int SD = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;

  cpu_step_ctrl_if bus_if ();

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .FAST_DIV        (FD),
    .SLOW_DIV        (SD)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Synchronizer pipes, a window of the last D synchronized button samples,
  // a mode number (0 halt, 1 step, 2 run) and a phase within the run period.
  bit          m_b1, m_b2, m_r1, m_r2, m_s1, m_s2, m_spd_prev;
  bit          m_btnD, m_btnD_prev, m_en;
  bit          m_hist[$];
  int          m_mode;
  int          m_phase;
  logic [31:0] m_cnt;

  task automatic model_reset();
    m_b1 = 0; m_b2 = 0; m_r1 = 0; m_r2 = 0; m_s1 = 0; m_s2 = 0;
    m_spd_prev = 0; m_btnD = 0; m_btnD_prev = 0; m_en = 0;
    m_hist.delete();
    m_mode = 0; m_phase = 0; m_cnt = 32'd0;
  endtask

  // Advance the model across one rising clock edge with the given raw inputs
  task automatic model_step(input bit b, input bit r, input bit s);
    bit req, tog, all_diff, nen;
    int period, nmode;
    req    = m_btnD && !m_btnD_prev;
    period = m_s2 ? SD : FD;
    tog    = (m_s2 != m_spd_prev);
    if (m_en) m_cnt = m_cnt + 32'd1;
    nen   = 0;
    nmode = m_mode;
    case (m_mode)
      0: begin
        m_phase = 0;
        if (m_r2) nmode = 2;
        else if (req) begin nmode = 1; nen = 1; end
      end
      1: nmode = 0;
      default: begin
        if (!m_r2) begin nmode = 0; m_phase = 0; end
        else if (tog && m_phase >= period - 1) m_phase = 0;
        else if (m_phase == period - 1) begin nen = 1; m_phase = 0; end
        else m_phase = m_phase + 1;
      end
    endcase
    m_mode = nmode;
    m_en   = nen;
    // Debounced level flips once the last D samples all disagree with it
    m_btnD_prev = m_btnD;
    m_hist.push_back(m_b2);
    if (m_hist.size() > D) void'(m_hist.pop_front());
    if (m_hist.size() == D) begin
      all_diff = 1;
      foreach (m_hist[i]) if (m_hist[i] == m_btnD) all_diff = 0;
      if (all_diff) m_btnD = m_b2;
    end
    m_b2 = m_b1; m_b1 = b;
    m_r2 = m_r1; m_r1 = r;
    m_spd_prev = m_s2;
    m_s2 = m_s1; m_s1 = s;
  endtask

  // Drive inputs at a falling edge, cross one rising edge, compare to model
  task automatic tick(input bit b, input bit r, input bit s);
    bus_if.btnStep = b;
    bus_if.swRun   = r;
    bus_if.swSpeed = s;
    model_step(b, r, s);
    @(negedge clk);
    check("model_cycle", {bus_if.cpuEn, bus_if.mode, bus_if.stepCount},
          {m_en, m_mode[1:0], m_cnt});
  endtask

  task automatic idle(input int n, input bit s);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, s);
  endtask

  typedef struct {
    bit          btn;
    bit          run;
    bit          spd;
    bit          en;
    logic [1:0]  mode;
    logic [31:0] cnt;
  } vec_t;

  vec_t        tbl[27];
  logic [63:0] en_mask, m1_mask;
  logic [31:0] base;
  logic [1:0]  mode6;
  int          npulse, acc;
  bit          rb, rr, rs;

  initial begin
    bus_if.btnStep = 1'b0;
    bus_if.swRun   = 1'b0;
    bus_if.swSpeed = 1'b0;
    model_reset();

    // Fast-run table: RUN for 21+ cycles, then exit
    acc = 0;
    for (int i = 0; i < 27; i++) begin
      tbl[i].btn  = 1'b0;
      tbl[i].spd  = 1'b0;
      tbl[i].run  = (i <= 22);
      tbl[i].mode = (i >= 2 && i <= 24) ? 2'd2 : 2'd0;
      tbl[i].en   = (i >= 4 && i <= 24 && (i % 2) == 0);
      tbl[i].cnt  = acc;
      if (tbl[i].en) acc++;
    end

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("reset_state", {bus_if.cpuEn, bus_if.mode, bus_if.stepCount}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("reset_held", {bus_if.cpuEn, bus_if.mode, bus_if.stepCount}, 64'd0);
    rst = 1'b0;

    // Reset mid-RUN with stepCount = 7 while cpuEn is high
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      if (bus_if.stepCount == 32'd7 && bus_if.cpuEn) break;
    end
    check("pre_reset_count", bus_if.stepCount, 64'd7);
    check("pre_reset_en", bus_if.cpuEn, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_en", bus_if.cpuEn, 64'd0);
    check("async_rst_mode", bus_if.mode, 64'd0);
    check("async_rst_count", bus_if.stepCount, 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick(1'b0, 1'b1, 1'b0);
    check("mode_after_reset", bus_if.mode, 64'd0);
    idle(6, 1'b0);

    // Table-driven fast run
    foreach (tbl[i]) begin
      tick(tbl[i].btn, tbl[i].run, tbl[i].spd);
      check("table_row", {bus_if.cpuEn, bus_if.mode, bus_if.stepCount},
            {tbl[i].en, tbl[i].mode, tbl[i].cnt});
    end
    idle(4, 1'b0);

    // Clean press: one step, in the cycle after edge t+6
    base = m_cnt; en_mask = '0; m1_mask = '0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      en_mask[i] = bus_if.cpuEn;
      m1_mask[i] = (bus_if.mode == 2'd1);
    end
    idle(10, 1'b0);
    check("press_en_timing", en_mask, 64'h40);
    check("press_mode_timing", m1_mask, 64'h40);
    check("press_count", bus_if.stepCount, 64'(base + 32'd1));

    // Bounce rejection: 1, 2 and 3 cycle pulses
    base = m_cnt; en_mask = '0;
    begin
      logic [8:0] pat;
      pat = 9'b0_1110_1101;
      for (int i = 0; i < 9; i++) begin
        tick(pat[i], 1'b0, 1'b0);
        en_mask[i] = bus_if.cpuEn;
      end
    end
    for (int i = 9; i < 19; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      en_mask[i] = bus_if.cpuEn;
    end
    check("bounce_en", en_mask, 64'd0);
    check("bounce_count", bus_if.stepCount, 64'(base));

    // Slow run, speed drops to fast while the divider is 3
    en_mask = '0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b1, (i < 9));
      en_mask[i] = bus_if.cpuEn;
    end
    check("speed_change_div3", en_mask, 64'hAA080);
    idle(6, 1'b0);

    // Slow run, speed drops to fast while the divider is 0
    en_mask = '0;
    for (int i = 0; i < 14; i++) begin
      tick(1'b0, 1'b1, (i < 6));
      en_mask[i] = bus_if.cpuEn;
    end
    check("speed_change_div0", en_mask, 64'h2A80);
    idle(6, 1'b0);

    // Step request and run in the same HALT cycle, then a press during RUN
    m1_mask = '0; npulse = 0; mode6 = 2'd0;
    for (int i = 0; i < 36; i++) begin
      tick((i < 16) || (i >= 24), (i >= 4), 1'b0);
      if (i == 6) mode6 = bus_if.mode;
      m1_mask[i] = (bus_if.mode == 2'd1);
      if (bus_if.cpuEn) npulse++;
    end
    check("conflict_mode", mode6, 64'd2);
    check("conflict_no_step", m1_mask, 64'd0);
    check("run_press_pulses", npulse, 64'd14);
    idle(10, 1'b0);

    // Counter wrap
    force dut.step_count = 32'hFFFF_FFFF;
    #1;
    release dut.step_count;
    m_cnt = 32'hFFFF_FFFF;
    check("wrap_preload", bus_if.stepCount, 64'hFFFF_FFFF);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0);
    idle(10, 1'b0);
    check("wrap_count", bus_if.stepCount, 64'd0);

    // Randomized stimulus against the model
    rb = 0; rr = 0; rs = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0)  rb = ~rb;
      if ($urandom_range(0, 59) == 0) rr = ~rr;
      if ($urandom_range(0, 39) == 0) rs = ~rs;
      if ($urandom_range(0, 799) == 0) begin
        #2 rst = 1'b1;
        #1;
        check("rand_reset", {bus_if.cpuEn, bus_if.mode, bus_if.stepCount}, 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
      end
      tick(rb, rr, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
